// File: rtl/seq_det_pkg.sv
// Shared types and width helpers for the round-robin serial pattern detector.
package seq_det_pkg;

  // Scheduler phases: wait for a word, shift its bits through the detector, save history.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WB    = 2'd2
  } state_t;

  // Match counter width and its saturation value.
  localparam int                CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_det_sched_if.sv
// Requester/match bus between the word producers and the shared detector.
interface seq_det_sched_if #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  import seq_det_pkg::*;

  localparam int CHW  = idx_w(NCH);
  localparam int POSW = idx_w(W);

  logic [NCH-1:0]   req_valid;
  logic [NCH*W-1:0] req_data;
  logic [NCH-1:0]   req_ready;
  logic             match_valid;
  logic [CHW-1:0]   match_ch;
  logic [POSW-1:0]  match_pos;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;

  // Producer side: offers words, observes grants and match reports.
  modport master (
    output req_valid, req_data,
    input  req_ready, match_valid, match_ch, match_pos, match_cnt, busy
  );

  // Scheduler side: grants one requester at a time and reports matches.
  modport slave (
    input  req_valid, req_data,
    output req_ready, match_valid, match_ch, match_pos, match_cnt, busy
  );

endinterface

// File: rtl/seq_det_step.sv
// One bit step of the serial pattern detector: compare, then shift or clear history.
module seq_det_step #(
  parameter int PLEN = 4,
  parameter int FW   = 2
) (
  input  logic [PLEN-2:0] i_hist,
  input  logic [FW-1:0]   i_fill,
  input  logic            i_bit,
  input  logic [PLEN-1:0] i_pattern,
  input  logic            i_overlap,
  output logic            o_match,
  output logic [PLEN-2:0] o_hist_nxt,
  output logic [FW-1:0]   o_fill_nxt
);

  localparam logic [FW-1:0] FULL = FW'(PLEN - 1);

  logic [PLEN-1:0] w_window;

  // Newest bit joins the saved history; a match needs a full history behind it.
  always_comb begin
    w_window   = {i_hist, i_bit};
    o_match    = (i_fill == FULL) && (w_window == i_pattern);
    o_hist_nxt = w_window[PLEN-2:0];
    o_fill_nxt = (i_fill == FULL) ? FULL : i_fill + 1'b1;
    if (o_match && !i_overlap) begin
      o_hist_nxt = '0;
      o_fill_nxt = '0;
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial pattern detector among NCH word requesters.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int W    = 8,
  parameter int PLEN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_en,
  input  logic [PLEN-1:0] cfg_pattern,
  input  logic            cfg_overlap,
  seq_det_sched_if.slave  bus
);

  localparam int CHW  = idx_w(NCH);
  localparam int POSW = idx_w(W);
  localparam int FW   = idx_w(PLEN);
  localparam int HW   = PLEN - 1;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [W-1:0]     r_word;
  logic [CHW-1:0]   r_ch;
  logic [PLEN-1:0]  r_pattern;
  logic             r_overlap;
  logic [HW-1:0]    r_hist;
  logic [FW-1:0]    r_fill;
  logic [POSW-1:0]  r_k;
  logic [CHW-1:0]   r_last_grant;

  logic [HW-1:0]    r_hist_mem [NCH];
  logic [FW-1:0]    r_fill_mem [NCH];

  logic             r_match_valid;
  logic [CHW-1:0]   r_match_ch;
  logic [POSW-1:0]  r_match_pos;
  logic [CNT_W-1:0] r_match_cnt;

  logic [CHW-1:0]   w_cand [NCH];
  logic             w_grant_ok;
  logic [CHW-1:0]   w_grant_ch;
  logic [NCH-1:0]   w_ready;
  logic             w_accept;
  logic             w_bit;
  logic             w_match;
  logic [HW-1:0]    w_hist_nxt;
  logic [FW-1:0]    w_fill_nxt;

  // Round-robin search: first requesting channel after the last one granted.
  always_comb begin
    w_grant_ok = 1'b0;
    w_grant_ch = '0;
    for (int j = 0; j < NCH; j++) begin
      w_cand[j] = CHW'((int'(r_last_grant) + 1 + j) % NCH);
      if (!w_grant_ok && bus.req_valid[w_cand[j]]) begin
        w_grant_ok = 1'b1;
        w_grant_ch = w_cand[j];
      end
    end
  end

  // One-hot ready, only offered while idle and enabled.
  always_comb begin
    w_ready = '0;
    if (r_state == IDLE && cfg_en && w_grant_ok) begin
      w_ready[w_grant_ch] = 1'b1;
    end
  end

  assign w_accept = |(w_ready & bus.req_valid);
  assign w_bit    = r_word[POSW'(W - 1) - r_k];

  seq_det_step #(
    .PLEN (PLEN),
    .FW   (FW)
  ) u_step (
    .i_hist     (r_hist),
    .i_fill     (r_fill),
    .i_bit      (w_bit),
    .i_pattern  (r_pattern),
    .i_overlap  (r_overlap),
    .o_match    (w_match),
    .o_hist_nxt (w_hist_nxt),
    .o_fill_nxt (w_fill_nxt)
  );

  // State register; reset abandons any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: accept -> W shift cycles -> one writeback cycle -> idle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SHIFT;
      SHIFT:   if (r_k == POSW'(W - 1)) w_state_nxt = WB;
      WB:      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Working registers: capture word and config at accept, then step through its bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word       <= '0;
      r_ch         <= '0;
      r_pattern    <= '0;
      r_overlap    <= 1'b0;
      r_hist       <= '0;
      r_fill       <= '0;
      r_k          <= '0;
      r_last_grant <= CHW'(NCH - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_word       <= bus.req_data[w_grant_ch*W +: W];
            r_ch         <= w_grant_ch;
            r_pattern    <= cfg_pattern;
            r_overlap    <= cfg_overlap;
            r_hist       <= r_hist_mem[w_grant_ch];
            r_fill       <= r_fill_mem[w_grant_ch];
            r_k          <= '0;
            r_last_grant <= w_grant_ch;
          end
        end
        SHIFT: begin
          r_hist <= w_hist_nxt;
          r_fill <= w_fill_nxt;
          r_k    <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Per-channel history slots: saved after each word, wiped while idle and disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_hist_mem[i] <= '0;
        r_fill_mem[i] <= '0;
      end
    end else if (r_state == WB) begin
      r_hist_mem[r_ch] <= r_hist;
      r_fill_mem[r_ch] <= r_fill;
    end else if (r_state == IDLE && !cfg_en) begin
      for (int i = 0; i < NCH; i++) begin
        r_hist_mem[i] <= '0;
        r_fill_mem[i] <= '0;
      end
    end
  end

  // Match report registers and saturating match counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_valid <= 1'b0;
      r_match_ch    <= '0;
      r_match_pos   <= '0;
      r_match_cnt   <= '0;
    end else begin
      r_match_valid <= 1'b0;
      if (r_state == SHIFT && w_match) begin
        r_match_valid <= 1'b1;
        r_match_ch    <= r_ch;
        r_match_pos   <= r_k;
        if (r_match_cnt != CNT_MAX) r_match_cnt <= r_match_cnt + 1'b1;
      end
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.match_valid = r_match_valid;
  assign bus.match_ch    = r_match_ch;
  assign bus.match_pos   = r_match_pos;
  assign bus.match_cnt   = r_match_cnt;
  assign bus.busy        = (r_state != IDLE);

endmodule
